// File: rtl/clk_div_n.sv
// clk_div_n: divides clk by a runtime-programmable N (2..2^DIV_W-1).
// Produces a registered divided clock out_clk, a one-cycle tick on each
// out_clk rising edge, and glitch-free divisor updates. A new divisor is
// staged in a pending register and only takes effect at a period boundary.
// Optional feature macro: CLK_DIV_ODD_DUTY50_EN. When it is defined, a
// negedge flop stretches odd-N high phases to an exact 50% duty.
module clk_div_n #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             out_clk,
  output logic             tick,
  output logic             upd_pending
);

  localparam logic [DIV_W-1:0] DEF  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO  = DIV_W'(2);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             upd_pending_q, upd_pending_d;
  logic             out_clk_q, out_clk_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt_inc;

  assign half    = div_act_q >> 1;
  assign cnt_inc = cnt_q + ONE;

  // Next-state: count/wrap while enabled, and stage any divisor load.
  always_comb begin
    cnt_d         = cnt_q;
    div_act_d     = div_act_q;
    div_pend_d    = div_pend_q;
    upd_pending_d = upd_pending_q;
    out_clk_d     = out_clk_q;
    tick_d        = 1'b0;
    if (en) begin
      if (cnt_q == div_act_q - ONE) begin
        // Period boundary: rising edge, and the only point a new N may land.
        cnt_d     = '0;
        out_clk_d = 1'b1;
        tick_d    = 1'b1;
        if (upd_pending_q) begin
          div_act_d     = div_pend_q;
          upd_pending_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc == half) out_clk_d = 1'b0;
      end
    end
    // A load on the wrap cycle is applied after the current boundary has
    // consumed the old pending value, so it lands on the following wrap.
    if (div_load) begin
      div_pend_d    = (div_val < TWO) ? TWO : div_val;
      upd_pending_d = 1'b1;
    end
  end

  // State registers; reset restarts with DEFAULT_DIV poised to wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= DEF - ONE;
      div_act_q     <= DEF;
      div_pend_q    <= DEF;
      upd_pending_q <= 1'b0;
      out_clk_q     <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      div_act_q     <= div_act_d;
      div_pend_q    <= div_pend_d;
      upd_pending_q <= upd_pending_d;
      out_clk_q     <= out_clk_d;
      tick_q        <= tick_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic out_neg_q, out_neg_d;

  // Half-cycle delayed copy of out_clk; only used for odd divisors.
  always_comb begin
    out_neg_d = out_clk_q & div_act_q[0];
  end

  // Negedge sampler that extends the odd-N high phase by half a clk period.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) out_neg_q <= 1'b0;
    else     out_neg_q <= out_neg_d;
  end

  assign out_clk = out_clk_q | out_neg_q;
`else
  assign out_clk = out_clk_q;
`endif

  assign tick        = tick_q;
  assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_clk_div_n.sv
// Testbench for clk_div_n: directed test-plan steps followed by random
// stimulus, all checked against a waveform-queue reference model.
module tb_clk_div_n;
  localparam int DIV_W = 8;
  localparam int DEFAULT_DIV = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             out_clk, tick, upd_pending;

  int tests = 0;
  int fails = 0;

  // Reference model: each period is pre-expanded into its waveform.
  int n_act, n_pend;
  bit pend_flag;
  bit q_out[$];
  bit q_tick[$];
  bit exp_out, exp_tick;

  clk_div_n #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .out_clk(out_clk), .tick(tick), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    n_act = DEFAULT_DIV; n_pend = DEFAULT_DIV; pend_flag = 0;
    q_out.delete(); q_tick.delete();
    exp_out = 0; exp_tick = 0;
  endtask

  task automatic model_edge(input bit e, input bit ld, input int v);
    if (e) begin
      if (q_out.size() == 0) begin
        if (pend_flag) begin n_act = n_pend; pend_flag = 0; end
        for (int i = 0; i < n_act; i++) begin
          q_out.push_back(i < n_act / 2);
          q_tick.push_back(i == 0);
        end
      end
      exp_out  = q_out.pop_front();
      exp_tick = q_tick.pop_front();
    end else begin
      exp_tick = 0;
    end
    if (ld) begin n_pend = clampv(v); pend_flag = 1; end
  endtask

  task automatic check(input string tag);
    tests += 3;
    assert (out_clk === exp_out) else begin
      fails++; $error("FAIL %s out_clk got=%b exp=%b t=%0t", tag, out_clk, exp_out, $time);
    end
    assert (tick === exp_tick) else begin
      fails++; $error("FAIL %s tick got=%b exp=%b t=%0t", tag, tick, exp_tick, $time);
    end
    assert (upd_pending === pend_flag) else begin
      fails++; $error("FAIL %s upd_pending got=%b exp=%b t=%0t", tag, upd_pending, pend_flag, $time);
    end
  endtask

  // One clk cycle: drive inputs, take the edge, check 1 time unit later.
  task automatic step(input string tag, input bit e, input bit ld, input int v);
    en = e; div_load = ld; div_val = DIV_W'(v);
    @(posedge clk);
    model_edge(e, ld, v);
    #1;
    check(tag);
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag, 1'b1, 1'b0, 0);
  endtask

  // Step until the model sees a rising edge (bounded).
  task automatic run_to_wrap(input string tag);
    int budget;
    budget = 0;
    do begin
      step(tag, 1'b1, 1'b0, 0);
      budget++;
    end while (!exp_tick && budget < 300);
    tests++;
    assert (exp_tick) else begin
      fails++; $error("FAIL %s wrap_timeout got=%0d exp<300", tag, budget);
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_async"});
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Default N=2
    run("div2", 8);
    // Load 5 mid-period
    step("load5", 1'b1, 1'b1, 5);
    run("div5", 16);
    // 6 then 3 before the boundary: only 3 applies
    run_to_wrap("sync6");
    step("load6", 1'b1, 1'b1, 6);
    step("load3", 1'b1, 1'b1, 3);
    run("div3", 12);
    // Clamp: 0 and 1 act as 2
    step("load0", 1'b1, 1'b1, 0);
    run("div0", 8);
    step("load1", 1'b1, 1'b1, 1);
    run("div1", 8);
    // N=4, freeze for 7 cycles while out_clk is high
    step("load4", 1'b1, 1'b1, 4);
    run_to_wrap("to4a");
    run_to_wrap("to4b");
    for (int i = 0; i < 7; i++) step("freeze", 1'b0, 1'b0, 0);
    step("freeze_load7", 1'b0, 1'b1, 7);
    run("resume4", 12);
    // Load coincident with a wrap goes to the following wrap
    step("load8", 1'b1, 1'b1, 8);
    run_to_wrap("to8");
    run("div8", 7);
    step("wrapload", 1'b1, 1'b1, 8);
    run("wrap_apply", 20);
    // N=8, reset between edges while out_clk high
    step("load8b", 1'b1, 1'b1, 8);
    run_to_wrap("to8b");
    run_to_wrap("to8c");
    step("hi8", 1'b1, 1'b1, 5);
    async_reset("rst8");
    run("after_rst", 8);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit e, ld;
      int v;
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
      else step("rnd", e, ld, v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
